conv1_mac_bank: RTL

- Layer-1 convolution engine, sitting directly downstream of the layer-1 weight ROM array (NUM parallel filters, 27 taps = 3x3x3, 5-bit address).
- Drives the ROM tap address and consumes the NUM combinational weight words.
- Multiplies each streamed activation by all NUM weights and accumulates 27 taps per output pixel.
- Emits NUM saturated fixed-point results per pixel over a valid/ready handshake.

---
 rtl/conv1_pkg.sv | 38 +++
 rtl/conv1_mac_lane.sv | 39 +++
 rtl/conv1_mac_bank.sv | 89 ++++++++
 3 files changed

// File: rtl/conv1_pkg.sv
// Shared types and constants for the layer-1 convolution MAC bank.
// sat_shift converts an accumulator back to the Q7.8 result format.
package conv1_pkg;

    localparam int WIDTH = 16;
    localparam int ADDR  = 5;
    localparam int NUM   = 64;
    localparam int TAPS  = 27;
    localparam int FRAC  = 8;
    localparam int ACC_W = 37;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    localparam acc_t  SAT_HI_ACC = acc_t'(2 ** (WIDTH - 1) - 1);
    localparam acc_t  SAT_LO_ACC = acc_t'(-(2 ** (WIDTH - 1)));
    localparam word_t SAT_HI     = word_t'(2 ** (WIDTH - 1) - 1);
    localparam word_t SAT_LO     = word_t'(-(2 ** (WIDTH - 1)));

    // Arithmetic shift floors toward minus infinity before the clamp.
    function automatic word_t sat_shift(input acc_t a);
        acc_t s;
        s = a >>> FRAC;
        if (s > SAT_HI_ACC) begin
            return SAT_HI;
        end else if (s < SAT_LO_ACC) begin
            return SAT_LO;
        end else begin
            return word_t'(s[WIDTH-1:0]);
        end
    endfunction

endpackage

// File: rtl/conv1_mac_lane.sv
// One filter lane: signed multiply, 27-tap accumulate and saturated
// result register that holds its value until the next window closes.
module conv1_mac_lane
    import conv1_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    last_i,
    input  logic signed [WIDTH-1:0] act_i,
    input  logic signed [WIDTH-1:0] weight_i,
    output logic signed [WIDTH-1:0] result_o
);

    logic signed [2*WIDTH-1:0] prod;
    acc_t                      acc_q;
    acc_t                      acc_d;
    word_t                     result_q;

    assign prod  = act_i * weight_i;
    assign acc_d = acc_q + acc_t'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            result_q <= '0;
        end else if (en_i) begin
            if (last_i) begin
                acc_q    <= '0;
                result_q <= sat_shift(acc_d);
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/conv1_mac_bank.sv
// Layer-1 convolution engine: streams 27 activation taps against NUM
// ROM weight words and hands out one saturated result vector per pixel.
//
// state  | meaning
// ACCUM  | accepting activation beats, address follows the tap counter
// OUTPUT | result vector presented, waiting for out_ready
module conv1_mac_bank
    import conv1_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic signed [WIDTH-1:0] act_data,
    output logic        [ADDR-1:0]  address,
    input  logic signed [WIDTH-1:0] weights  [0:NUM-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data [0:NUM-1]
);

    localparam logic [ADDR-1:0] TAP_LAST = ADDR'(TAPS - 1);

    state_t          state_q;
    logic [ADDR-1:0] tap_q;
    logic [ADDR-1:0] tap_d;
    logic            out_valid_q;
    logic            act_ready_q;
    logic            accept;
    logic            last;

    assign accept = act_valid & act_ready_q;
    assign last   = accept && (tap_q == TAP_LAST);

    always_comb begin
        tap_d = tap_q;
        if (accept) begin
            tap_d = last ? '0 : tap_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            act_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    tap_q <= tap_d;
                    if (last) begin
                        out_valid_q <= 1'b1;
                        act_ready_q <= 1'b0;
                        state_q     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        act_ready_q <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    // tap_q is already zero whenever the FSM sits in OUTPUT.
    assign address   = tap_q;
    assign act_ready = act_ready_q;
    assign out_valid = out_valid_q;

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        conv1_mac_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .en_i     (accept),
            .last_i   (last),
            .act_i    (act_data),
            .weight_i (weights[g]),
            .result_o (out_data[g])
        );
    end

endmodule
